// File: rtl/dec_round_key_buffer_if.sv
// dec_round_key_buffer_if: key-generator control, key capture and round-key replay signals
interface dec_round_key_buffer_if #(parameter int BLOCK_LENGTH = 128);
   logic start, gen_en, key_in_valid, busy, keys_ready, rk_req, rk_valid;
   logic [3:0] gen_round, rk_round;
   logic [BLOCK_LENGTH-1:0] key_in, rk_out;
   modport master (
      output start, key_in, key_in_valid, rk_req,
      input gen_en, gen_round, busy, keys_ready, rk_out, rk_round, rk_valid
   );
   modport slave (
      input start, key_in, key_in_valid, rk_req,
      output gen_en, gen_round, busy, keys_ready, rk_out, rk_round, rk_valid
   );
endinterface

// File: rtl/dec_round_key_buffer.sv
// dec_round_key_buffer: expands K0..K10 via the key generator, stores them, replays K10..K0 on request
module dec_round_key_buffer #(
   parameter int BLOCK_LENGTH = 128,
   parameter int NUM_ROUNDS = 10
) (
   input logic clk,
   input logic rst,
   dec_round_key_buffer_if.slave bus
);
   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
   typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
   state_t state, state_nx;
   logic [BLOCK_LENGTH-1:0] mem [0:NUM_ROUNDS];
   logic [3:0] wr_ptr, rd_ptr;
   logic skip, cap, serve;
   // skip drops the generator's lagging output from before a (re)start
   assign cap = state == FILL && bus.key_in_valid && !bus.start && !skip;
   assign serve = state == READY && bus.rk_req && !bus.start;
   assign bus.busy = state == FILL;
   assign bus.keys_ready = state == READY;
   always_comb begin
      state_nx = bus.start ? FILL : (cap && wr_ptr == LAST) ? READY : state;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bus.gen_en <= 1'b0;
         bus.gen_round <= '0;
         wr_ptr <= '0;
         rd_ptr <= LAST;
         skip <= 1'b0;
         bus.rk_out <= '0;
         bus.rk_round <= '0;
         bus.rk_valid <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) mem[i] <= '0;
      end else begin
         skip <= bus.start;
         bus.rk_valid <= serve;
         if (bus.start) begin
            bus.gen_en <= 1'b1;
            bus.gen_round <= '0;
            wr_ptr <= '0;
            rd_ptr <= LAST;
         end else if (bus.gen_en) begin
            bus.gen_en <= bus.gen_round != LAST;
            bus.gen_round <= bus.gen_round == LAST ? bus.gen_round : bus.gen_round + 4'd1;
         end
         if (cap) begin
            mem[wr_ptr] <= bus.key_in;
            wr_ptr <= wr_ptr + 4'd1;
         end
         if (serve) begin
            bus.rk_out <= mem[rd_ptr];
            bus.rk_round <= rd_ptr;
            rd_ptr <= rd_ptr == 4'd0 ? LAST : rd_ptr - 4'd1;
         end
      end
endmodule

// File: tb/tb_dec_round_key_buffer.sv
// tb_dec_round_key_buffer: generator model plus scoreboard of expected replayed round keys
module tb_dec_round_key_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   dec_round_key_buffer_if bus ();
   dec_round_key_buffer dut (.clk(clk), .rst(rst), .bus(bus));
   logic [127:0] ktab [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
   typedef struct packed {logic req; logic [3:0] round;} vec_t;
   vec_t tbl [16];
   logic [3:0] exp_q [$];
   logic [3:0] mon_r;
   int n_chk = 0;
   int n_fail = 0;
   // key generator model: registered output one cycle after an enabled round
   always @(posedge clk or negedge rst)
      if (!rst) begin
         bus.key_in_valid <= 1'b0;
         bus.key_in <= '0;
      end else begin
         bus.key_in_valid <= bus.gen_en;
         bus.key_in <= bus.gen_en ? ktab[bus.gen_round] : '0;
      end
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (rst && bus.rk_valid) begin
         if (exp_q.size() == 0) chk("unexpected rk_valid", bus.rk_valid, 0);
         else begin
            mon_r = exp_q.pop_front();
            chk("rk_round", bus.rk_round, mon_r);
            chk("rk_out", bus.rk_out, ktab[mon_r]);
         end
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic s, input logic r, input logic push, input logic [3:0] round);
      bus.start = s;
      bus.rk_req = r;
      if (push) exp_q.push_back(round);
      tick();
      bus.start = 1'b0;
      bus.rk_req = 1'b0;
   endtask
   task automatic fill(input string name, input logic with_req, input logic poke);
      int n = 0;
      bus.start = 1'b1;
      bus.rk_req = with_req;
      tick();
      bus.start = 1'b0;
      bus.rk_req = 1'b0;
      chk({name, " busy"}, bus.busy, 1);
      chk({name, " gen_en"}, bus.gen_en, 1);
      chk({name, " gen_round"}, bus.gen_round, 0);
      chk({name, " keys_ready low"}, bus.keys_ready, 0);
      chk({name, " rk_valid low"}, bus.rk_valid, 0);
      while (!bus.keys_ready && n < 40) begin
         bus.rk_req = poke && (n % 3 == 1);
         tick();
         n++;
      end
      bus.rk_req = 1'b0;
      chk({name, " ready latency"}, n, 12);
   endtask
   task automatic replay(input string name);
      for (int i = 0; i <= 10; i++) drive(1'b0, 1'b1, 1'b1, 4'(10 - i));
      chk({name, " last rk_round"}, bus.rk_round, 0);
      chk({name, " last rk_out"}, bus.rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      tick();
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      for (int i = 0; i < 13; i++) tbl[i] = '{1'b1, 4'(i < 11 ? 10 - i : 21 - i)};
      tbl[13] = '{1'b0, 4'd0};
      tbl[14] = '{1'b1, 4'd8};
      tbl[15] = '{1'b0, 4'd0};
      bus.start = 1'b0;
      bus.rk_req = 1'b0;
      #12;
      chk("reset gen_en", bus.gen_en, 0);
      chk("reset gen_round", bus.gen_round, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset keys_ready", bus.keys_ready, 0);
      chk("reset rk_out", bus.rk_out, 0);
      chk("reset rk_round", bus.rk_round, 0);
      chk("reset rk_valid", bus.rk_valid, 0);
      #5 rst = 1'b1;
      tick();
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      chk("idle req rk_valid", bus.rk_valid, 0);
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      chk("idle req keys_ready", bus.keys_ready, 0);
      fill("fill", 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 4'd10);
      chk("first rk_out", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("first rk_round", bus.rk_round, 10);
      for (int i = 1; i <= 10; i++) drive(1'b0, 1'b1, 1'b1, 4'(10 - i));
      chk("replay last rk_round", bus.rk_round, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, tbl[i].req, tbl[i].req, tbl[i].round);
         chk("table rk_valid", bus.rk_valid, tbl[i].req);
      end
      fill("start+req", 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 4'd10);
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.gen_round != 4'd5 && n < 20) begin
         tick();
         n++;
      end
      chk("restart at round 5", bus.gen_round, 5);
      fill("restart", 1'b0, 1'b0);
      replay("restart");
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 4'(10 - i));
      tick();
      drive(1'b0, 1'b1, 1'b1, 4'd5);
      chk("pre-reset rk_valid", bus.rk_valid, 1);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      chk("async gen_en", bus.gen_en, 0);
      chk("async gen_round", bus.gen_round, 0);
      chk("async busy", bus.busy, 0);
      chk("async keys_ready", bus.keys_ready, 0);
      chk("async rk_out", bus.rk_out, 0);
      chk("async rk_round", bus.rk_round, 0);
      chk("async rk_valid", bus.rk_valid, 0);
      #3 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 4'd0);
         chk("post-reset rk_valid", bus.rk_valid, 0);
      end
      chk("post-reset keys_ready", bus.keys_ready, 0);
      tick();
      chk("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
